// File: rtl/codificador_prioridade_seq.sv
// Sequential N-to-W priority encoder with valid/ack output handshake.
// Request lines are latched into a pending register; the highest set
// pending bit is emitted as a binary code and cleared on the same edge.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no code presented (valid=0); loads as soon as pend != 0
// HOLD  | code on a is valid; held until ack, then next code or IDLE
module codificador_prioridade_seq #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  input  logic         ack,
  output logic [W-1:0] a,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         load;
  logic [W-1:0] idx;
  logic [N-1:0] clr;
  logic [N-1:0] req;
  logic [N-1:0] pend_next;
  logic         merge;

  // Index of the highest set pending bit; later (higher) bits override.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) idx = W'(i);
    end
  end

  // Next state and load decision; loads only ever look at registered pend.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (pend != '0) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (pend != '0) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending update: clear the loaded bit, then OR in new requests so a
  // same-edge request on the cleared bit survives as a fresh request.
  always_comb begin
    clr = '0;
    if (load) clr[idx] = 1'b1;
    req       = en ? d : '0;
    pend_next = (pend & ~clr) | req;
    merge     = |(req & pend & ~clr);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: output code, pending set, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      if (load) a <= idx;
      pend <= pend_next;
      if (merge) ovf <= 1'b1;
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_codificador_prioridade_seq.sv
// Bench for codificador_prioridade_seq: directed vectors, accepted codes
// checked against a queue of hand-computed expected codes.
module tb_codificador_prioridade_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d;
  logic       ack;
  logic [2:0] a;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int vectors;
  int miscompares;
  logic [2:0] exp_q[$];

  codificador_prioridade_seq #(.N(8), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d),
    .ack   (ack),
    .a     (a),
    .valid (valid),
    .pend  (pend),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs are driven and outputs checked 2ns after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: a code is accepted when valid and ack are both high at an edge.
  always @(negedge clk) begin
    if (rst_n && valid && ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL code_unexpected: got %0d expected none at %0t", a, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL code: got %0d expected %0d at %0t", a, e, $time);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    d     = '0;
    ack   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_a", 8'(a), 8'd0);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_pend", pend, 8'h00);
    chk("rst_ovf", 8'(ovf), 8'd0);

    // Single request.
    en = 1'b1; ack = 1'b1; d = 8'b0000_0100;
    exp_q.push_back(3'd2);
    step(); d = '0;
    chk("single_pend1", pend, 8'h04);
    chk("single_valid1", 8'(valid), 8'd0);
    step();
    chk("single_a", 8'(a), 8'd2);
    chk("single_valid2", 8'(valid), 8'd1);
    chk("single_pend2", pend, 8'h00);
    step();
    chk("single_valid3", 8'(valid), 8'd0);
    chk("single_a_hold", 8'(a), 8'd2);

    // Multiple requests, back-to-back drain.
    d = 8'b1001_0010;
    exp_q.push_back(3'd7); exp_q.push_back(3'd4); exp_q.push_back(3'd1);
    step(); d = '0;
    chk("drain_pend0", pend, 8'h92);
    step();
    chk("drain_a7", 8'(a), 8'd7); chk("drain_pend1", pend, 8'h12);
    chk("drain_v7", 8'(valid), 8'd1);
    step();
    chk("drain_a4", 8'(a), 8'd4); chk("drain_pend2", pend, 8'h02);
    chk("drain_v4", 8'(valid), 8'd1);
    step();
    chk("drain_a1", 8'(a), 8'd1); chk("drain_pend3", pend, 8'h00);
    chk("drain_v1", 8'(valid), 8'd1);
    step();
    chk("drain_idle", 8'(valid), 8'd0);

    // Backpressure.
    ack = 1'b0; d = 8'h92;
    step(); d = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_a", 8'(a), 8'd7);
      chk("bp_valid", 8'(valid), 8'd1);
      chk("bp_pend", pend, 8'h12);
      step();
    end
    chk("bp_ovf", 8'(ovf), 8'd0);

    // New request on bit 3, then merge into it while code 7 is held.
    d = 8'h08;
    step();
    chk("new3_pend", pend, 8'h1A);
    chk("new3_ovf", 8'(ovf), 8'd0);
    step(); d = '0;
    chk("merge_pend", pend, 8'h1A);
    chk("merge_ovf", 8'(ovf), 8'd1);

    // Release with a same-edge request on the bit being loaded.
    ack = 1'b1; d = 8'h10;
    exp_q.push_back(3'd7); exp_q.push_back(3'd4); exp_q.push_back(3'd4);
    exp_q.push_back(3'd3); exp_q.push_back(3'd1);
    step(); d = '0;
    chk("coll_a", 8'(a), 8'd4);
    chk("coll_pend", pend, 8'h1A);
    chk("coll_ovf", 8'(ovf), 8'd1);
    step();
    chk("coll_a4b", 8'(a), 8'd4); chk("coll_pend2", pend, 8'h0A);
    step();
    chk("coll_a3", 8'(a), 8'd3); chk("coll_pend3", pend, 8'h02);
    step();
    chk("coll_a1", 8'(a), 8'd1); chk("coll_pend4", pend, 8'h00);
    step();
    chk("coll_idle", 8'(valid), 8'd0);
    chk("ovf_sticky", 8'(ovf), 8'd1);

    // Asynchronous reset mid-transfer with pend=0x92, valid=1.
    ack = 1'b0; d = 8'h92;
    step();
    step(); d = '0; en = 1'b0;
    chk("pre_rst_pend", pend, 8'h92);
    chk("pre_rst_valid", 8'(valid), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a", 8'(a), 8'd0);
    chk("arst_valid", 8'(valid), 8'd0);
    chk("arst_pend", pend, 8'h00);
    chk("arst_ovf", 8'(ovf), 8'd0);
    step();
    rst_n = 1'b1;

    // Enable gating.
    en = 1'b0; d = 8'hFF; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gate_pend", pend, 8'h00);
      chk("gate_valid", 8'(valid), 8'd0);
      chk("gate_ovf", 8'(ovf), 8'd0);
    end
    en = 1'b1; d = 8'h01;
    exp_q.push_back(3'd0);
    step(); d = '0;
    chk("gate_pend1", pend, 8'h01);
    chk("gate_valid1", 8'(valid), 8'd0);
    step();
    chk("gate_a0", 8'(a), 8'd0);
    chk("gate_valid2", 8'(valid), 8'd1);
    step();
    chk("gate_idle", 8'(valid), 8'd0);

    step();
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/codificador_prioridade_seq.md
Name: codificador_prioridade_seq

Overview:
- Sequential 8-to-3 priority encoder; the inverse of the team's 3-to-8 decoder.
- Latches request lines into a pending register.
- Emits the binary index of the highest-priority pending line on a registered output with valid/ack handshake, then clears that bit.
- Sits between decoder-driven request lines and any consumer that needs a binary code stream, e.g. decoder output looped back for round-trip checks.

Parameters:
N, 8, number of request lines; must equal 2**W
W, 3, width of the output code

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; 1 = sample d this cycle
d  input  N  request lines, any number may be high
ack  input  1  consumer accepts current code (meaningful only when valid=1)
a  output  W  encoded index of the request being presented
valid  output  1  a holds a valid code
pend  output  N  pending-request register (observability)
ovf  output  1  sticky: a request was merged into an already-pending bit

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (any time, including mid-transfer):
  - a=0, valid=0, pend=0, ovf=0, state IDLE.
  - All in-flight requests are discarded.
- Priority: highest index wins (bit N-1 highest, bit 0 lowest).
- Capture: at each rising edge with en=1, pend_next = (pend & ~clr) | d.
  - clr is the one-hot bit being loaded into a this edge (0 if no load).
  - en=0: d ignored, but pend still drains through loads.
- Set/clear collision: if d[i]=1 at the same edge pend[i] is cleared by a load, set wins.
  - pend[i] stays 1 and counts as a new request.
  - ovf not raised.
- Merge: if d[i]=1, en=1, pend[i]=1 and bit i is not being cleared that edge:
  - pend unchanged.
  - ovf <= 1 and stays 1 until reset.
- State machine:
  - IDLE (valid=0): if pend!=0, load a = index of highest set bit of pend, set valid=1, clear that bit; go HOLD. Else stay.
  - HOLD (valid=1), ack=0: a, valid held stable; pend still accepts new requests.
  - HOLD, ack=1 and pend!=0: load next code the same edge (back-to-back, one code per cycle); stay HOLD.
  - HOLD, ack=1 and pend=0: valid<=0, a holds last value; go IDLE.
- Loads use the registered pend, never the same-cycle d.
- Latency: d high before edge k -> pend bit set after edge k -> valid/a after edge k+1 (2 cycles from idle).
- ack while valid=0 is ignored.
- Throughput: one code per cycle with ack held 1.
- a is never X after reset; a only changes on a load.

Test Plan:
1. Reset: drive rst_n=0 asynchronously mid-cycle with pend=0x92, valid=1 -> a=0, valid=0, pend=0x00, ovf=0 immediately, before the next edge.
2. Single request: en=1, ack=1, d=8'b0000_0100 for one cycle -> pend=0x04 after edge 1; a=3'd2, valid=1, pend=0x00 after edge 2; valid=0 after edge 3.
3. Multiple, drain: en=1, ack=1, d=8'b1001_0010 for one cycle -> a=7,4,1 on three consecutive cycles with valid=1; pend 0x92->0x12->0x02->0x00; then valid=0.
4. Backpressure: ack=0 while a=7, valid=1 for 5 cycles with pend=0x12 -> a=7, valid=1, pend=0x12 stable; raise ack -> a=4 next edge.
5. Overflow and collision:
   - d=0x08 while pend[3]=1 and code 7 is held (ack=0) -> ovf=1, pend unchanged; ovf stays 1 after drain.
   - d=0x10 on the edge that loads code 4 -> pend[4]=1 afterwards, ovf unchanged.
6. Enable gating: en=0, d=0xFF for 4 cycles from idle -> pend=0x00, valid=0, ovf=0; then en=1, d=0x01 one cycle -> a=0, valid=1 two edges later.
